change_event_logger: RTL and testbench

//   Hardware counterpart of the "@time change in r or b" monitor. Watches two

---
 rtl/change_event_logger_if.sv | 27 ++
 rtl/change_event_logger.sv | 123 ++++++++++++
 tb/tb_change_event_logger.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_event_logger_if.sv
// Event read-out bus of change_event_logger: show-ahead FIFO head plus handshake.
// Latency: n/a (wiring only).
// Backpressure: the reader holds ev_ready low to stall; the head stays stable meanwhile.
//   ev_valid  head entry present         ev_ready  reader accepts head
//   ev_time   head timestamp             ev_chg    head change mask {b, r}
//   ev_r      head r value               ev_b      head b value
interface change_event_logger_if #(
    parameter int WIDTH    = 32,
    parameter int TS_WIDTH = 16
) ();
    logic                ev_valid;
    logic                ev_ready;
    logic [TS_WIDTH-1:0] ev_time;
    logic [1:0]          ev_chg;
    logic [WIDTH-1:0]    ev_r;
    logic [WIDTH-1:0]    ev_b;

    modport master (
        output ev_valid, ev_time, ev_chg, ev_r, ev_b,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_time, ev_chg, ev_r, ev_b,
        output ev_ready
    );
endinterface

// File: rtl/change_event_logger.sv
// Logs every change of two watched buses as {timestamp, change mask, r, b} into a FIFO.
// Latency: a change seen at edge k is at the FIFO head right after edge k (empty FIFO).
// Backpressure: ev_ready low stalls the head; pushes into a full FIFO without a pop are dropped and counted.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              1 = log changes, 0 = track values only
//   r_in, b_in          watched buses
//   ev (master)         event read-out bus (valid/ready, show-ahead)
//   count               entries held, 0..DEPTH
//   overflow, drop_cnt  sticky drop flag and saturating drop counter
//   ovf_clr             synchronous clear of overflow and drop_cnt
module change_event_logger #(
    parameter int  WIDTH    = 32,
    parameter int  TS_WIDTH = 16,
    parameter int  DEPTH    = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      r_in,
    input  logic [WIDTH-1:0]      b_in,
    change_event_logger_if.master ev,
    output logic [AW:0]           count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [7:0]            drop_cnt
);

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [1:0]          chg;
        logic [WIDTH-1:0]    r;
        logic [WIDTH-1:0]    b;
    } entry_t;

    logic [TS_WIDTH-1:0] ts;
    logic                primed;
    logic [WIDTH-1:0]    prev_r;
    logic [WIDTH-1:0]    prev_b;
    // Counters carry one extra bit so full and empty are distinguishable.
    logic [AW:0]         wr_cnt;
    logic [AW:0]         rd_cnt;
    entry_t              mem [DEPTH];

    logic [1:0]          chg;
    logic                push;
    logic                pop;
    logic                full;
    logic                wr_en;
    logic                drop;
    logic                head_vld;
    entry_t              entry_in;
    entry_t              head;

    always_comb begin
        // The first edge after reset reports both buses as changed, like a
        // simulator's initial-value event.
        chg      = primed ? {b_in != prev_b, r_in != prev_r} : 2'b11;
        push     = enable && (chg != 2'b00);
        count    = wr_cnt - rd_cnt;
        head_vld = (count != '0);
        full     = (count == (AW+1)'(DEPTH));
        pop      = head_vld && ev.ev_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        wr_en    = push && (!full || pop);
        drop     = push && full && !pop;
        entry_in = '{ts: ts, chg: chg, r: r_in, b: b_in};
        head     = mem[rd_cnt[AW-1:0]];
    end

    // Head fields read zero whenever nothing is held (including during reset).
    assign ev.ev_valid = head_vld;
    assign ev.ev_time  = head_vld ? head.ts  : '0;
    assign ev.ev_chg   = head_vld ? head.chg : '0;
    assign ev.ev_r     = head_vld ? head.r   : '0;
    assign ev.ev_b     = head_vld ? head.b   : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts       <= '0;
            primed   <= 1'b0;
            prev_r   <= '0;
            prev_b   <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts     <= ts + TS_WIDTH'(1);
            primed <= 1'b1;
            // Previous values track the buses even while logging is disabled.
            prev_r <= r_in;
            prev_b <= b_in;
            if (wr_en) begin
                wr_cnt <= wr_cnt + (AW+1)'(1);
            end
            if (pop) begin
                rd_cnt <= rd_cnt + (AW+1)'(1);
            end
            // A drop on the same edge as a clear wins: the new drop is counted.
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_clr) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt[AW-1:0]] <= entry_in;
        end
    end

endmodule

// File: tb/tb_change_event_logger.sv
// Directed self-checking bench for change_event_logger (WIDTH=32, TS_WIDTH=16, DEPTH=8).
// Inputs change and outputs are sampled on the falling edge; each task checks its own scenario.
module tb_change_event_logger;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] r_in = '0;
    logic [31:0] b_in = '0;
    logic [3:0]  count;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int tb_ts;

    change_event_logger_if #(.WIDTH(32), .TS_WIDTH(16)) ev_if ();

    change_event_logger #(.WIDTH(32), .TS_WIDTH(16), .DEPTH(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .r_in     (r_in),
        .b_in     (b_in),
        .ev       (ev_if),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Edges since reset release: the timestamp the next entry will carry.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_ts <= 0;
        else          tb_ts <= tb_ts + 1;
    end

    // {ev_valid, ev_time, ev_chg, ev_r, ev_b}
    logic [82:0] head;
    assign head = {ev_if.ev_valid, ev_if.ev_time, ev_if.ev_chg, ev_if.ev_r, ev_if.ev_b};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        r_in = '0;
        b_in = '0;
        ovf_clr = 1'b0;
        ev_if.ev_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        r_in = '0;
        b_in = '0;
        ev_if.ev_ready = 1'b0;
        tick();
        n_cmp++;
        if ({count, overflow, drop_cnt} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_status: got count=%0d ovf=%0b drop=%0d, want 0/0/0", count, overflow, drop_cnt);
        end
        n_cmp++;
        if (head !== 83'd0) begin
            n_err++;
            $display("FAIL reset_head: got %h, want 0", head);
        end
        tick();
        reset_n = 1'b1;
        tick(); // ts=0: prime event
        n_cmp++;
        if (head !== {1'b1, 16'd0, 2'b11, 32'd0, 32'd0} || count !== 4'd1) begin
            n_err++;
            $display("FAIL prime_entry: got head=%h count=%0d, want ts=0 chg=11 r=0 b=0 count=1", head, count);
        end
        tick();
        tick(); // ts=1,2: stable inputs, nothing new; head held while not ready
        n_cmp++;
        if (head !== {1'b1, 16'd0, 2'b11, 32'd0, 32'd0} || count !== 4'd1) begin
            n_err++;
            $display("FAIL stable_no_entry: got head=%h count=%0d, want prime held count=1", head, count);
        end
    endtask

    task automatic test_change_r_b();
        r_in = 32'd5;
        ev_if.ev_ready = 1'b1;
        tick(); // ts=3: prime popped, r entry pushed
        n_cmp++;
        if (head !== {1'b1, 16'd3, 2'b01, 32'd5, 32'd0} || count !== 4'd1) begin
            n_err++;
            $display("FAIL r_change: got head=%h count=%0d, want ts=3 chg=01 r=5 b=0", head, count);
        end
        tick(); // ts=4
        n_cmp++;
        if (ev_if.ev_valid !== 1'b0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL r_one_cycle: got valid=%0b count=%0d, want 0/0", ev_if.ev_valid, count);
        end
        tick(); // ts=5
        b_in = 32'd9;
        tick(); // ts=6
        n_cmp++;
        if (head !== {1'b1, 16'd6, 2'b10, 32'd5, 32'd9}) begin
            n_err++;
            $display("FAIL b_change: got head=%h, want ts=6 chg=10 r=5 b=9", head);
        end
        tick();
        n_cmp++;
        if (ev_if.ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b_one_cycle: got valid=%0b, want 0", ev_if.ev_valid);
        end
    endtask

    task automatic test_same_edge();
        logic [15:0] exp_ts;
        exp_ts = 16'(tb_ts);
        r_in = 32'd7;
        b_in = 32'd14;
        tick();
        n_cmp++;
        if (head !== {1'b1, exp_ts, 2'b11, 32'd7, 32'd14} || count !== 4'd1) begin
            n_err++;
            $display("FAIL same_edge: got head=%h count=%0d, want ts=%0d chg=11 r=7 b=14 count=1", head, count, exp_ts);
        end
        tick();
        n_cmp++;
        if (count !== 4'd0) begin
            n_err++;
            $display("FAIL same_edge_single: got count=%0d, want 0", count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tick(); // ts=0 prime
        for (int i = 1; i <= 9; i++) begin
            r_in = i;
            tick(); // ts=i
        end
        n_cmp++;
        if ({count, overflow, drop_cnt} !== {4'd8, 1'b1, 8'd2}) begin
            n_err++;
            $display("FAIL overflow: got count=%0d ovf=%0b drop=%0d, want 8/1/2", count, overflow, drop_cnt);
        end
        ovf_clr = 1'b1;
        tick(); // ts=10
        ovf_clr = 1'b0;
        n_cmp++;
        if ({count, overflow, drop_cnt} !== {4'd8, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL ovf_clr: got count=%0d ovf=%0b drop=%0d, want 8/0/0", count, overflow, drop_cnt);
        end
        n_cmp++;
        if (head !== {1'b1, 16'd0, 2'b11, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL full_head: got %h, want prime entry", head);
        end
    endtask

    task automatic test_full_pushpop();
        r_in = 32'd10;
        ev_if.ev_ready = 1'b1;
        tick(); // ts=11: pop prime, push r=10
        n_cmp++;
        if ({count, overflow, drop_cnt} !== {4'd8, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL full_pushpop: got count=%0d ovf=%0b drop=%0d, want 8/0/0", count, overflow, drop_cnt);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 7; i++) begin
            n_cmp++;
            if (head !== {1'b1, 16'(i), 2'b01, 32'(i), 32'd0}) begin
                n_err++;
                $display("FAIL drain_%0d: got %h, want ts=%0d chg=01 r=%0d b=0", i, head, i, i);
            end
            tick();
        end
        n_cmp++;
        if (head !== {1'b1, 16'd11, 2'b01, 32'd10, 32'd0}) begin
            n_err++;
            $display("FAIL drain_last: got %h, want ts=11 chg=01 r=10 b=0", head);
        end
        tick();
        tick(); // ready while empty
        n_cmp++;
        if (count !== 4'd0 || ev_if.ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty: got count=%0d valid=%0b, want 0/0", count, ev_if.ev_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        tick(); // prime
        for (int i = 1; i <= 267; i++) begin
            r_in = i;
            tick();
        end
        n_cmp++;
        if ({count, overflow, drop_cnt} !== {4'd8, 1'b1, 8'd255}) begin
            n_err++;
            $display("FAIL drop_saturate: got count=%0d ovf=%0b drop=%0d, want 8/1/255", count, overflow, drop_cnt);
        end
        r_in = 32'd300;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if ({overflow, drop_cnt} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL drop_beats_clr: got ovf=%0b drop=%0d, want 1/1", overflow, drop_cnt);
        end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        r_in = 32'd1;
        tick(); // prime
        n_cmp++;
        if (head !== {1'b1, 16'd0, 2'b11, 32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL prime_r1: got %h, want ts=0 chg=11 r=1 b=0", head);
        end
        ev_if.ev_ready = 1'b1;
        tick();
        ev_if.ev_ready = 1'b0;
        enable = 1'b0;
        r_in = 32'd2;
        tick();
        enable = 1'b1;
        tick();
        n_cmp++;
        if (count !== 4'd0) begin
            n_err++;
            $display("FAIL enable_off: got count=%0d, want 0", count);
        end
        for (int i = 3; i <= 5; i++) begin
            r_in = i;
            tick();
        end
        n_cmp++;
        if (count !== 4'd3) begin
            n_err++;
            $display("FAIL pending3: got count=%0d, want 3", count);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ev_if.ev_valid !== 1'b0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%0b count=%0d, want 0/0", ev_if.ev_valid, count);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (head !== {1'b1, 16'd0, 2'b11, 32'd5, 32'd0} || count !== 4'd1) begin
            n_err++;
            $display("FAIL reprime: got head=%h count=%0d, want ts=0 chg=11 r=5 b=0 count=1", head, count);
        end
    endtask

    task automatic test_ts_wrap();
        int guard;
        do_reset();
        ev_if.ev_ready = 1'b1;
        guard = 0;
        while (tb_ts != 65535 && guard < 70000) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (tb_ts != 65535) begin
            n_err++;
            $display("FAIL wrap_wait: got edge count %0d, want 65535", tb_ts);
        end
        r_in = 32'd1;
        tick();
        n_cmp++;
        if (head !== {1'b1, 16'd65535, 2'b01, 32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL ts_max: got %h, want ts=65535 chg=01 r=1", head);
        end
        r_in = 32'd2;
        tick();
        n_cmp++;
        if (head !== {1'b1, 16'd0, 2'b01, 32'd2, 32'd0}) begin
            n_err++;
            $display("FAIL ts_wrap: got %h, want ts=0 chg=01 r=2", head);
        end
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        test_reset();
        test_change_r_b();
        test_same_edge();
        test_overflow();
        test_full_pushpop();
        test_drain();
        test_saturate();
        test_enable_and_reset();
        test_ts_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
